// File: rtl/avmm_segled_ctrl_pkg.sv
// Shared constants, types and the 7-segment encoder for the Avalon-MM segment LED controller.
package avmm_segled_ctrl_pkg;

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrCtrl   = 2'd1;
  localparam logic [1:0] AddrStatus = 2'd2;

  localparam int unsigned CtrlW       = 9;
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlSignBit = 1;
  localparam int unsigned CtrlDotLsb  = 2;
  localparam int unsigned CtrlLzbBit  = 8;

  localparam int unsigned NumDigits = 6;
  localparam int unsigned BcdW      = 4 * NumDigits;
  localparam logic [31:0] DataMax   = 32'd999999;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SegDigit0 = 7'h40;
  localparam logic [6:0] SegDigit1 = 7'h79;
  localparam logic [6:0] SegDigit2 = 7'h24;
  localparam logic [6:0] SegDigit3 = 7'h30;
  localparam logic [6:0] SegDigit4 = 7'h19;
  localparam logic [6:0] SegDigit5 = 7'h12;
  localparam logic [6:0] SegDigit6 = 7'h02;
  localparam logic [6:0] SegDigit7 = 7'h78;
  localparam logic [6:0] SegDigit8 = 7'h00;
  localparam logic [6:0] SegDigit9 = 7'h10;
  localparam logic [6:0] SegBlank  = 7'h7F;
  localparam logic [6:0] SegMinus  = 7'h3F;

  typedef enum logic [1:0] {StIdle, StShift, StLoad} conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SegDigit0;
      4'd1:    pat = SegDigit1;
      4'd2:    pat = SegDigit2;
      4'd3:    pat = SegDigit3;
      4'd4:    pat = SegDigit4;
      4'd5:    pat = SegDigit5;
      4'd6:    pat = SegDigit6;
      4'd7:    pat = SegDigit7;
      4'd8:    pat = SegDigit8;
      4'd9:    pat = SegDigit9;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/avmm_segled_ctrl_if.sv
// Avalon-MM slave bus bundle between the Nios II fabric and the segment LED controller.
interface avmm_segled_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/avmm_segled_ctrl_bin2bcd.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, then a one-cycle LOAD state.
module avmm_segled_ctrl_bin2bcd
  import avmm_segled_ctrl_pkg::*;
#(
  parameter int unsigned BIN_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BcdW-1:0]  bcd_o
);

  localparam int unsigned CntW = $clog2(BIN_W);
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

  conv_state_e      state_q;
  logic [BIN_W-1:0] bin_q;
  logic [BcdW-1:0]  bcd_q;
  logic [BcdW-1:0]  bcd_adj;
  logic [CntW-1:0]  cnt_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NumDigits; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // A start in any state abandons the current conversion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      state_q <= StShift;
      bin_q   <= bin_i;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StShift: begin
          {bcd_q, bin_q} <= {bcd_adj[BcdW-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StLoad;
          end
        end
        StLoad:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StLoad);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/avmm_segled_ctrl.sv
// Avalon-MM register file, BCD display latch, digit scanner and blanking/sign output stage.
module avmm_segled_ctrl
  import avmm_segled_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BIN_W    = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  avmm_segled_ctrl_if.slave avs,
  output logic [5:0]        sel,
  output logic [7:0]        seg_led
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

  logic             wr_data, wr_ctrl;
  logic [BIN_W-1:0] wdata_sat;
  logic [BIN_W-1:0] data_q;
  logic [CtrlW-1:0] ctrl_q;
  logic             start_q;
  logic             busy;
  logic [31:0]      rdata_d, rdata_q;

  logic             conv_busy, conv_done;
  logic [BcdW-1:0]  conv_bcd;
  logic [BcdW-1:0]  latch_q;

  logic [ScanW-1:0] scan_q;
  logic [2:0]       idx_q;

  logic [2:0]       msd;
  logic [2:0]       minus_pos;
  logic             show_minus;
  logic [5:0]       dot;
  logic [6:0]       pattern;
  logic [5:0]       sel_d, sel_q;
  logic [7:0]       seg_d, seg_q;

  assign wr_data   = avs.avs_write && (avs.avs_address == AddrData);
  assign wr_ctrl   = avs.avs_write && (avs.avs_address == AddrCtrl);
  assign wdata_sat = (avs.avs_writedata > DataMax) ? BIN_W'(DataMax)
                                                   : avs.avs_writedata[BIN_W-1:0];
  assign busy      = start_q | conv_busy;

  avmm_segled_ctrl_bin2bcd #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .start_i (start_q),
    .bin_i   (data_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    rdata_d = '0;
    unique case (avs.avs_address)
      AddrData:   rdata_d[BIN_W-1:0] = data_q;
      AddrCtrl:   rdata_d[CtrlW-1:0] = ctrl_q;
      AddrStatus: rdata_d[0]         = busy;
      default:    rdata_d            = '0;
    endcase
  end

  // A pending restart suppresses the load so a superseded value never reaches the latch
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      start_q <= 1'b0;
      rdata_q <= '0;
      latch_q <= '0;
    end else begin
      start_q <= wr_data;
      if (wr_data) begin
        data_q <= wdata_sat;
      end
      if (wr_ctrl) begin
        ctrl_q <= avs.avs_writedata[CtrlW-1:0];
      end
      if (avs.avs_read) begin
        rdata_q <= rdata_d;
      end
      if (conv_done && !start_q) begin
        latch_q <= conv_bcd;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == ScanLast) begin
      scan_q <= '0;
      idx_q  <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  always_comb begin
    msd = '0;
    for (int i = 1; i < NumDigits; i++) begin
      if (latch_q[4*i +: 4] != 4'd0) begin
        msd = 3'(i);
      end
    end
  end

  // Sign only fits when the top digit is free, i.e. the value is at most 99999
  assign show_minus = ctrl_q[CtrlSignBit] && (latch_q[BcdW-1 -: 4] == 4'd0);
  assign minus_pos  = ctrl_q[CtrlLzbBit] ? msd + 3'd1 : 3'd5;
  assign dot        = ctrl_q[CtrlDotLsb +: NumDigits];

  always_comb begin
    pattern = seg_encode(latch_q[{idx_q, 2'b00} +: 4]);
    if (ctrl_q[CtrlLzbBit] && (idx_q > msd)) begin
      pattern = SegBlank;
    end
    if (show_minus && (idx_q == minus_pos)) begin
      pattern = SegMinus;
    end
    if (ctrl_q[CtrlEnBit]) begin
      sel_d = ~(6'b1 << idx_q);
      seg_d = {~dot[idx_q], pattern};
    end else begin
      sel_d = 6'h3F;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel_q <= 6'h3F;
      seg_q <= 8'hFF;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel              = sel_q;
  assign seg_led          = seg_q;
  assign avs.avs_readdata = rdata_q;

endmodule

// File: tb/tb_avmm_segled_ctrl.sv
// Self-checking bench: register access, BUSY timing, display vectors and reset corner cases.
module tb_avmm_segled_ctrl;
  import avmm_segled_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] sel;
  logic [7:0] seg_led;

  int checks;
  int failures;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] ctrl;
    logic [2:0]  idx;
    logic [7:0]  seg;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vecs[NumVec];

  avmm_segled_ctrl_if bus ();

  avmm_segled_ctrl #(
    .SCAN_DIV (4),
    .BIN_W    (20)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .avs     (bus),
    .sel     (sel),
    .seg_led (seg_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    bus.avs_read = 1'b0;
    check(name_q.pop_front(), bus.avs_readdata, exp_q.pop_front());
  endtask

  task automatic expect_digit(input string name, input int idx, input logic [7:0] exp);
    logic [5:0] want;
    bit         found;
    want  = ~(6'b1 << idx);
    found = 1'b0;
    exp_q.push_back({24'h0, exp});
    name_q.push_back(name);
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (sel == want) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: digit %0d never selected, sel=%0h", name_q.pop_front(), idx, sel);
      void'(exp_q.pop_front());
    end else begin
      check(name_q.pop_front(), {24'h0, seg_led}, exp_q.pop_front());
    end
  endtask

  initial begin
    int busy_cnt;
    int bad;
    int seen5;
    logic [31:0] held;

    checks   = 0;
    failures = 0;
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;

    vecs[0]  = '{32'd123456, 32'h001, 3'd0, 8'h82};
    vecs[1]  = '{32'd123456, 32'h001, 3'd5, 8'hF9};
    vecs[2]  = '{32'd123456, 32'h001, 3'd2, 8'h99};
    vecs[3]  = '{32'd123456, 32'h001, 3'd3, 8'hB0};
    vecs[4]  = '{32'd42,     32'h101, 3'd0, 8'hA4};
    vecs[5]  = '{32'd42,     32'h101, 3'd1, 8'h99};
    vecs[6]  = '{32'd42,     32'h101, 3'd2, 8'hFF};
    vecs[7]  = '{32'd42,     32'h101, 3'd5, 8'hFF};
    vecs[8]  = '{32'd42,     32'h103, 3'd2, 8'hBF};
    vecs[9]  = '{32'd42,     32'h103, 3'd3, 8'hFF};
    vecs[10] = '{32'd42,     32'h003, 3'd5, 8'hBF};
    vecs[11] = '{32'd42,     32'h003, 3'd4, 8'hC0};
    vecs[12] = '{32'd2000000, 32'h001, 3'd3, 8'h90};
    vecs[13] = '{32'd2000000, 32'h003, 3'd5, 8'h90};
    vecs[14] = '{32'd7,      32'h009, 3'd1, 8'h40};
    vecs[15] = '{32'd7,      32'h009, 3'd0, 8'hF8};
    vecs[16] = '{32'd0,      32'h101, 3'd0, 8'hC0};
    vecs[17] = '{32'd0,      32'h101, 3'd1, 8'hFF};
    vecs[18] = '{32'd0,      32'h103, 3'd1, 8'hBF};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel", {26'h0, sel}, 32'h3F);
    check("rst_seg", {24'h0, seg_led}, 32'hFF);
    check("rst_rdata", bus.avs_readdata, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_sel", {26'h0, sel}, 32'h3F);
    check("idle_seg", {24'h0, seg_led}, 32'hFF);
    bus_read(AddrData, 32'h0, "rd_data_rst");
    bus_read(AddrCtrl, 32'h0, "rd_ctrl_rst");
    bus_read(AddrStatus, 32'h0, "rd_status_rst");
    bus_read(2'd3, 32'h0, "rd_reserved");

    // Register masking and read-only status
    bus_write(AddrCtrl, 32'hFFFF_FFFF);
    bus_read(AddrCtrl, 32'h1FF, "ctrl_mask");
    bus_write(AddrStatus, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(AddrStatus, 32'h0, "status_ro");
    bus_read(2'd3, 32'h0, "reserved_ro");
    bus_write(AddrCtrl, 32'h0);

    // BUSY high for 22 cycles after a DATA write
    bus_write(AddrData, 32'd123456);
    bus.avs_address = AddrStatus;
    bus.avs_read    = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.avs_readdata[0]) busy_cnt++;
    end
    bus.avs_read = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'd22);

    // Same-cycle read and write: read returns the old value
    @(negedge clk);
    bus.avs_address   = AddrData;
    bus.avs_writedata = 32'd11;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b1;
    exp_q.push_back(32'd123456);
    name_q.push_back("rw_same_cycle");
    @(negedge clk);
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
    check(name_q.pop_front(), bus.avs_readdata, exp_q.pop_front());
    bus_read(AddrData, 32'd11, "rw_after");

    // Saturation and readdata hold
    bus_write(AddrData, 32'd2000000);
    bus_read(AddrData, 32'hF423F, "data_sat");
    bus.avs_address = AddrCtrl;
    repeat (3) @(negedge clk);
    held = bus.avs_readdata;
    check("rdata_hold", held, 32'hF423F);
    bus_write(AddrData, 32'd999999);
    bus_read(AddrData, 32'hF423F, "data_max_exact");

    // EN=0 keeps the display dark while the scan runs
    bus_write(AddrCtrl, 32'h1FE);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sel != 6'h3F || seg_led != 8'hFF) bad++;
    end
    check("en0_dark", 32'(bad), 32'd0);

    for (int v = 0; v < NumVec; v++) begin
      bus_write(AddrData, vecs[v].data);
      bus_write(AddrCtrl, vecs[v].ctrl);
      repeat (25) @(negedge clk);
      expect_digit($sformatf("vec%0d_digit%0d", v, vecs[v].idx), int'(vecs[v].idx),
                   vecs[v].seg);
    end

    // Last write wins: 5 is superseded 3 cycles later by 7
    bus_write(AddrCtrl, 32'h001);
    bus_write(AddrData, 32'd0);
    repeat (30) @(negedge clk);
    bus_write(AddrData, 32'd5);
    @(negedge clk);
    bus_write(AddrData, 32'd7);
    bus.avs_address = AddrStatus;
    bus.avs_read    = 1'b1;
    busy_cnt = 0;
    seen5    = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.avs_readdata[0]) busy_cnt++;
      if (sel == 6'h3E && seg_led == 8'h92) seen5++;
    end
    bus.avs_read = 1'b0;
    check("restart_busy", 32'(busy_cnt), 32'd22);
    check("never_shows_5", 32'(seen5), 32'd0);
    expect_digit("restart_digit0", 0, 8'hF8);

    // Reset in the middle of a conversion
    bus_write(AddrCtrl, 32'h009);
    bus_write(AddrData, 32'd123456);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", {26'h0, sel}, 32'h3F);
    check("midrst_seg", {24'h0, seg_led}, 32'hFF);
    check("midrst_rdata", bus.avs_readdata, 32'h0);
    rst = 1'b0;
    bus_read(AddrStatus, 32'h0, "midrst_busy");
    bus_read(AddrData, 32'h0, "midrst_data");
    bus_read(AddrCtrl, 32'h0, "midrst_ctrl");
    bus_write(AddrCtrl, 32'h001);
    expect_digit("midrst_digit0", 0, 8'hC0);
    repeat (30) @(negedge clk);
    expect_digit("midrst_digit5", 5, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
